// File: rtl/aes_ctrl_pkg.sv
// Shared types and sizing helpers for the AES round sequencer.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } rctrl_state_t;

    localparam int BLK_W = 128;

    // Bits needed to count rounds 0..nr inclusive.
    function automatic int rk_width(input int nr);
        return (nr < 2) ? 1 : $clog2(nr + 1);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Bundle between the round sequencer, the block load/unload logic, key store and round datapath.
// AES_RCTRL_ABORT_EN adds the abort request line.
interface aes_round_ctrl_if #(
    parameter int BLK_W = aes_ctrl_pkg::BLK_W,
    parameter int RK_W  = aes_ctrl_pkg::rk_width(10)
);
    logic             start;
    logic [BLK_W-1:0] din;
    logic             ready;
    logic [RK_W-1:0]  rk_idx;
    logic [BLK_W-1:0] rk;
    logic [BLK_W-1:0] rf_in;
    logic             rf_last;
    logic [BLK_W-1:0] rf_out;
    logic             done;
    logic [BLK_W-1:0] dout;
`ifdef AES_RCTRL_ABORT_EN
    logic             abort;

    modport slave (
        input  start, din, rk, rf_out, abort,
        output ready, rk_idx, rf_in, rf_last, done, dout
    );
    modport master (
        output start, din, rk, rf_out, abort,
        input  ready, rk_idx, rf_in, rf_last, done, dout
    );
`else
    modport slave (
        input  start, din, rk, rf_out,
        output ready, rk_idx, rf_in, rf_last, done, dout
    );
    modport master (
        output start, din, rk, rf_out,
        input  ready, rk_idx, rf_in, rf_last, done, dout
    );
`endif
endinterface

// File: rtl/AddRK.sv
// AddRoundKey: bitwise XOR of the state with the round key.
module AddRK #(
    parameter int W = 128
) (
    output logic [W-1:0] y,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b
);
    assign y = a ^ b;
endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: owns state and round counter, applies AddRK, drives key index and round datapath.
// AES_RCTRL_ABORT_EN enables the abort input.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int BLK_W = aes_ctrl_pkg::BLK_W,
    parameter int NR    = 10,
    parameter int RK_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    aes_round_ctrl_if.slave bus
);
    localparam logic [RK_W-1:0] LAST_RND = RK_W'(NR);

    rctrl_state_t     r_fsm;
    rctrl_state_t     w_fsm_nxt;
    logic [RK_W-1:0]  r_round;
    logic [BLK_W-1:0] r_state;
    logic [BLK_W-1:0] r_dout;
    logic [BLK_W-1:0] w_ark_a;
    logic [BLK_W-1:0] w_ark_y;
    logic             w_last;
    logic             w_abort;

`ifdef AES_RCTRL_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last  = (r_round == LAST_RND);
    // Single AddRK: plaintext whitening in IDLE, round result otherwise.
    assign w_ark_a = (r_fsm == IDLE) ? bus.din : bus.rf_out;

    AddRK #(.W(BLK_W)) u_addrk (
        .y (w_ark_y),
        .a (w_ark_a),
        .b (bus.rk)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_fsm <= IDLE;
        else       r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (bus.start) w_fsm_nxt = ROUND;
            ROUND: begin
                if (w_abort)     w_fsm_nxt = IDLE;
                else if (w_last) w_fsm_nxt = DONE;
            end
            DONE:    w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready   = 1'b0;
        bus.rk_idx  = '0;
        bus.rf_last = 1'b0;
        bus.done    = 1'b0;
        case (r_fsm)
            IDLE:  bus.ready = 1'b1;
            ROUND: begin
                bus.rk_idx  = r_round;
                bus.rf_last = w_last;
            end
            DONE:  bus.done = ~w_abort;
            default: ;
        endcase
    end

    assign bus.rf_in = r_state;
    assign bus.dout  = r_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_round <= '0;
            r_state <= '0;
            r_dout  <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= w_ark_y;
                        r_round <= RK_W'(1);
                    end
                end
                ROUND: begin
                    if (w_abort) begin
                        r_round <= '0;
                        r_state <= '0;
                    end else begin
                        r_state <= w_ark_y;
                        // Counter parks at NR; the result is captured on the way into DONE.
                        if (w_last) r_dout  <= w_ark_y;
                        else        r_round <= r_round + 1'b1;
                    end
                end
                DONE: begin
                    r_round <= '0;
                    if (w_abort) r_state <= '0;
                end
                default: r_round <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with an identity stub and a full AES-128 round model.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_round_ctrl_if #(.BLK_W(128), .RK_W(4)) bus();

    aes_round_ctrl #(.BLK_W(128), .NR(10), .RK_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [127:0] sb[$];
    logic [127:0] exp_v;
    logic [127:0] last_exp = '0;
    bit   mode = 1'b0;            // 0: identity stub, 1: AES round model
    logic [7:0]   sbox_t[256];
    logic [127:0] rkeys[16];
    logic [3:0]   trace_idx[32];
    logic         trace_last[32];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++)
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[v] = s;
        end
    endtask

    task automatic build_keys(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rkeys[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        logic [7:0] b[16];
        logic [7:0] t[16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    function automatic logic [127:0] rk_of(input logic [3:0] idx);
        return mode ? rkeys[idx] : {32{idx}};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] s = d ^ rk_of(4'd0);
        for (int r = 1; r <= 10; r++)
            s = (mode ? round_fn(s, r == 10) : s) ^ rk_of(4'(r));
        return s;
    endfunction

    // Key store and round datapath stand-ins.
    always @(*) begin
        bus.rk     = rk_of(bus.rk_idx);
        bus.rf_out = mode ? round_fn(bus.rf_in, bus.rf_last) : bus.rf_in;
    end

    // Scoreboard: every done pulse must match the oldest expected block.
    always @(negedge clk) begin
        if (bus.done) begin
            n_done++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done dout=%h required no done", bus.dout);
            end else begin
                exp_v = sb.pop_front();
                last_exp = exp_v;
                if (bus.dout !== exp_v) begin
                    errors++;
                    $display("FAIL sb_dout got=%h required=%h", bus.dout, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [127:0] d);
        bus.din   = d;
        bus.start = 1'b1;
        sb.push_back(model(d));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            trace_idx[c]  = bus.rk_idx;
            trace_last[c] = bus.rf_last;
            if (bus.done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", bus.done); end
        checks++; if (bus.dout !== 128'h0) begin errors++; $display("FAIL reset_dout got=%h required=0", bus.dout); end
        checks++; if (bus.rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got=%0d required=0", bus.rk_idx); end
        checks++; if (bus.rf_last !== 1'b0) begin errors++; $display("FAIL reset_rf_last got=%b required=0", bus.rf_last); end
        checks++; if (bus.rf_in !== 128'h0) begin errors++; $display("FAIL reset_rf_in got=%h required=0", bus.rf_in); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int cyc;
        int bad;
        mode = 1'b0;
        drive_start(128'h0);
        wait_done(20, cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL id_latency got=%0d required=11", cyc); end
        checks++; if (bus.dout !== {32{4'hB}}) begin errors++; $display("FAIL id_dout got=%h required=%h", bus.dout, {32{4'hB}}); end
        bad = -1;
        for (int k = 1; k <= 10; k++) if (trace_idx[k] !== 4'(k) && bad < 0) bad = k;
        checks++; if (bad >= 0) begin errors++; $display("FAIL id_rk_idx cycle=%0d got=%0d required=%0d", bad, trace_idx[bad], bad); end
        tick();
        checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL id_return ready=%b done=%b required ready=1 done=0", bus.ready, bus.done); end
    endtask

    task automatic test_golden();
        int cyc;
        int bad;
        mode = 1'b1;
        build_keys(128'h000102030405060708090a0b0c0d0e0f);
        drive_start(128'h00112233445566778899aabbccddeeff);
        wait_done(20, cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL aes_latency got=%0d required=11", cyc); end
        checks++; if (bus.dout !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL aes_dout got=%h required=69c4e0d86a7b0430d8cdb78070b4c55a", bus.dout); end
        bad = -1;
        for (int k = 1; k <= 11; k++) if (trace_last[k] !== (k == 10) && bad < 0) bad = k;
        checks++; if (bad >= 0) begin errors++; $display("FAIL aes_rf_last cycle=%0d got=%b required=%b", bad, trace_last[bad], bad == 10); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        int bad_rdy = -1;
        int bad_done = -1;
        bit er, ed;
        mode = 1'b1;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        bus.din = a;
        bus.start = 1'b1;
        sb.push_back(model(a));
        for (int c = 0; c <= 26; c++) begin
            @(negedge clk);
            er = (c == 0) || (c == 12) || (c >= 24);
            ed = (c == 11) || (c == 23);
            if (bus.ready !== er && bad_rdy < 0) bad_rdy = c;
            if (bus.done !== ed && bad_done < 0) bad_done = c;
            if (c == 12) begin
                bus.din = b;
                sb.push_back(model(b));
            end
            if (c == 13) bus.start = 1'b0;
        end
        checks++; if (bad_rdy >= 0) begin errors++; $display("FAIL b2b_ready first bad cycle=%0d required none", bad_rdy); end
        checks++; if (bad_done >= 0) begin errors++; $display("FAIL b2b_done first bad cycle=%0d required none", bad_done); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d required=0", sb.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        int cyc;
        mode = 1'b0;
        drive_start(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b required=1", bus.ready); end
        checks++; if (bus.dout !== 128'h0) begin errors++; $display("FAIL rst_mid_dout got=%h required=0", bus.dout); end
        sb.delete();
        d0 = n_done;
        tick();
        tick();
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (n_done != d0) begin errors++; $display("FAIL rst_mid_no_done got=%0d required=%0d", n_done, d0); end
        tick();
        mode = 1'b1;
        drive_start(128'hdead_beef_cafe_f00d_1234_5678_9abc_def0);
        wait_done(20, cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL rst_mid_restart got=%0d required=11", cyc); end
        tick();
    endtask

    task automatic test_busy_ignore();
        int d0;
        int cyc;
        mode = 1'b1;
        d0 = n_done;
        drive_start(128'h3243f6a8885a308d313198a2e0370734);
        repeat (2) @(negedge clk);
        tick();
        bus.start = 1'b1;
        bus.din   = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
        tick();
        bus.start = 1'b0;
        bus.din   = '0;
        wait_done(20, cyc);
        checks++; if (cyc != 8) begin errors++; $display("FAIL busy_latency got=%0d required=8", cyc); end
        tick();
        repeat (13) @(negedge clk);
        checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL busy_done_count got=%0d required=%0d", n_done - d0, 1); end
        tick();
    endtask

`ifdef AES_RCTRL_ABORT_EN
    task automatic test_abort();
        int d0;
        int cyc;
        logic [127:0] prev;
        mode = 1'b0;
        prev = last_exp;
        drive_start(128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa);
        repeat (3) @(negedge clk);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b required=1", bus.ready); end
        checks++; if (bus.dout !== prev) begin errors++; $display("FAIL abort_dout got=%h required=%h", bus.dout, prev); end
        checks++; if (bus.rf_in !== 128'h0) begin errors++; $display("FAIL abort_state got=%h required=0", bus.rf_in); end
        sb.delete();
        d0 = n_done;
        repeat (14) @(negedge clk);
        checks++; if (n_done != d0) begin errors++; $display("FAIL abort_no_done got=%0d required=%0d", n_done, d0); end
        tick();
        drive_start(128'h1);
        repeat (10) tick();
        bus.abort = 1'b1;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_in_done got=%b required=0", bus.done); end
        tick();
        bus.abort = 1'b0;
        sb.delete();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_done_ready got=%b required=1", bus.ready); end
        bus.abort = 1'b1;
        drive_start(128'h2);
        bus.abort = 1'b0;
        wait_done(20, cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL abort_idle_start got=%0d required=11", cyc); end
        tick();
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.din   = '0;
`ifdef AES_RCTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        build_sbox();
        for (int r = 0; r < 16; r++) rkeys[r] = '0;
        test_reset();
        test_identity();
        test_golden();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
`ifdef AES_RCTRL_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached required completion");
        $fatal(1, "watchdog");
    end

endmodule
